// File: rtl/qdr_traffic_gen.sv
// Write/read-compare traffic generator for port 0 of the QDRII+ controller user interface.
// Writes an address-derived pattern over a fixed range, reads it back and flags any mismatch.
module qdr_traffic_gen #(
    parameter int unsigned           ADDR_WIDTH      = 18,
    parameter int unsigned           DATA_WIDTH      = 36,
    parameter int unsigned           BURST_LEN       = 4,
    parameter int unsigned           BW_WIDTH        = 4,
    parameter int unsigned           START_ADDR      = 0,
    parameter int unsigned           END_ADDR        = 255,
    parameter int unsigned           MAX_OUTSTANDING = 16,
    parameter logic [DATA_WIDTH-1:0] SEED            = DATA_WIDTH'(36'h5A5A5A5A5)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               init_calib_complete,
    input  logic                               start,
    output logic                               app_wr_cmd0,
    output logic [ADDR_WIDTH-1:0]              app_wr_addr0,
    output logic [DATA_WIDTH*BURST_LEN-1:0]    app_wr_data0,
    output logic [BW_WIDTH*BURST_LEN-1:0]      app_wr_bw_n0,
    output logic                               app_rd_cmd0,
    output logic [ADDR_WIDTH-1:0]              app_rd_addr0,
    input  logic                               app_rd_valid0,
    input  logic [DATA_WIDTH*BURST_LEN-1:0]    app_rd_data0,
    output logic                               busy,
    output logic                               tg_compare_error,
    output logic [ADDR_WIDTH-1:0]              err_addr,
    output logic [15:0]                        pass_cnt
);

    localparam int unsigned UW  = DATA_WIDTH * BURST_LEN;
    localparam int unsigned BWW = BW_WIDTH * BURST_LEN;
    localparam int unsigned OW  = $clog2(MAX_OUTSTANDING) + 1;

    localparam logic [ADDR_WIDTH-1:0] FIRST   = ADDR_WIDTH'(START_ADDR);
    localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(END_ADDR);
    localparam logic [OW-1:0]         OUT_MAX = OW'(MAX_OUTSTANDING);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    // Word k of the burst at address A is {A, k} zero-extended and XORed with SEED.
    function automatic logic [UW-1:0] pattern(input logic [ADDR_WIDTH-1:0] addr);
        logic [UW-1:0] burst;
        burst = '0;
        for (int k = 0; k < BURST_LEN; k++) begin
            burst[k*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'({addr, 2'(k)}) ^ SEED;
        end
        return burst;
    endfunction

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH-1:0]  exp_addr_q, exp_addr_d;
    logic [OW-1:0]          outstanding_q, outstanding_d;
    logic                   pass_err_q, pass_err_d;
    logic                   wr_cmd_q, wr_cmd_d;
    logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
    logic [UW-1:0]          wr_data_q, wr_data_d;
    logic [BWW-1:0]         wr_bw_n_q, wr_bw_n_d;
    logic                   rd_cmd_q, rd_cmd_d;
    logic [ADDR_WIDTH-1:0]  rd_addr_q, rd_addr_d;
    logic                   busy_q, busy_d;
    logic                   cmp_err_q, cmp_err_d;
    logic [ADDR_WIDTH-1:0]  err_addr_q, err_addr_d;
    logic [15:0]            pass_cnt_q, pass_cnt_d;

    logic rd_issue;
    logic rd_valid_live;
    logic underflow;
    logic mismatch;

    always_comb begin
        // NOTE: every signal written here gets a default first so no path infers a latch.
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        exp_addr_d    = exp_addr_q;
        outstanding_d = outstanding_q;
        pass_err_d    = pass_err_q;
        wr_cmd_d      = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        wr_bw_n_d     = '1;
        rd_cmd_d      = 1'b0;
        rd_addr_d     = rd_addr_q;
        cmp_err_d     = cmp_err_q;
        err_addr_d    = err_addr_q;
        pass_cnt_d    = pass_cnt_q;
        rd_issue      = 1'b0;

        // Returns only count while reads can legitimately be in flight.
        rd_valid_live = app_rd_valid0 && (state_q == S_READ || state_q == S_DRAIN);
        underflow     = rd_valid_live && (outstanding_q == '0);
        mismatch      = rd_valid_live && (underflow || (app_rd_data0 != pattern(exp_addr_q)));

        case (state_q)
            S_IDLE: begin
                if (init_calib_complete && start) begin
                    wr_ptr_d   = FIRST;
                    exp_addr_d = FIRST;
                    pass_err_d = 1'b0;
                    state_d    = S_WRITE;
                end
            end
            S_WRITE: begin
                if (!init_calib_complete) begin
                    state_d = S_IDLE;
                end else begin
                    wr_cmd_d  = 1'b1;
                    wr_bw_n_d = '0;
                    wr_addr_d = wr_ptr_q;
                    wr_data_d = pattern(wr_ptr_q);
                    wr_ptr_d  = wr_ptr_q + 1'b1;
                    if (wr_ptr_q == LAST) begin
                        rd_ptr_d = FIRST;
                        state_d  = S_READ;
                    end
                end
            end
            S_READ: begin
                if (!init_calib_complete) begin
                    state_d = S_IDLE;
                end else if (outstanding_q < OUT_MAX) begin
                    rd_issue  = 1'b1;
                    rd_cmd_d  = 1'b1;
                    rd_addr_d = rd_ptr_q;
                    rd_ptr_d  = rd_ptr_q + 1'b1;
                    if (rd_ptr_q == LAST) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (!init_calib_complete) begin
                    state_d = S_IDLE;
                end else if (outstanding_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (!pass_err_q && pass_cnt_q != 16'hFFFF) begin
                    pass_cnt_d = pass_cnt_q + 16'd1;
                end
                if (init_calib_complete && start) begin
                    wr_ptr_d   = FIRST;
                    exp_addr_d = FIRST;
                    pass_err_d = 1'b0;
                    state_d    = S_WRITE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // An abort drops all in-flight reads; a spurious return never decrements below zero.
        if (state_d == S_IDLE) begin
            outstanding_d = '0;
        end else begin
            outstanding_d = outstanding_q + OW'(rd_issue) - OW'(rd_valid_live && !underflow);
        end

        if (rd_valid_live) begin
            exp_addr_d = exp_addr_q + 1'b1;
        end

        if (mismatch) begin
            pass_err_d = 1'b1;
            cmp_err_d  = 1'b1;
            if (!cmp_err_q) begin
                err_addr_d = exp_addr_q;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            exp_addr_q    <= '0;
            outstanding_q <= '0;
            pass_err_q    <= 1'b0;
            wr_cmd_q      <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            wr_bw_n_q     <= '1;
            rd_cmd_q      <= 1'b0;
            rd_addr_q     <= '0;
            busy_q        <= 1'b0;
            cmp_err_q     <= 1'b0;
            err_addr_q    <= '0;
            pass_cnt_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            exp_addr_q    <= exp_addr_d;
            outstanding_q <= outstanding_d;
            pass_err_q    <= pass_err_d;
            wr_cmd_q      <= wr_cmd_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            wr_bw_n_q     <= wr_bw_n_d;
            rd_cmd_q      <= rd_cmd_d;
            rd_addr_q     <= rd_addr_d;
            busy_q        <= busy_d;
            cmp_err_q     <= cmp_err_d;
            err_addr_q    <= err_addr_d;
            pass_cnt_q    <= pass_cnt_d;
        end
    end

    assign app_wr_cmd0      = wr_cmd_q;
    assign app_wr_addr0     = wr_addr_q;
    assign app_wr_data0     = wr_data_q;
    assign app_wr_bw_n0     = wr_bw_n_q;
    assign app_rd_cmd0      = rd_cmd_q;
    assign app_rd_addr0     = rd_addr_q;
    assign busy             = busy_q;
    assign tg_compare_error = cmp_err_q;
    assign err_addr         = err_addr_q;
    assign pass_cnt         = pass_cnt_q;

endmodule

// File: tb/tb_qdr_traffic_gen.sv
// Bench for qdr_traffic_gen: a fixed-latency controller model with a write/read scoreboard,
// plus a second instance configured for a single-address range.
module tb_qdr_traffic_gen;

    localparam int AW  = 18;
    localparam int DW  = 36;
    localparam int BL  = 4;
    localparam int UW  = DW * BL;
    localparam int BWW = 16;
    localparam logic [DW-1:0] SEED = 36'h5A5A5A5A5;

    logic            clk, rst;
    logic            icc, start, wr_cmd, rd_cmd, rd_valid, busy, tg_err;
    logic [AW-1:0]   wr_addr, rd_addr, err_addr;
    logic [UW-1:0]   wr_data, rd_data;
    logic [BWW-1:0]  bw_n;
    logic [15:0]     pass_cnt;

    logic            icc_s, start_s, wr_cmd_s, rd_cmd_s, rd_valid_s, busy_s, tg_err_s;
    logic [AW-1:0]   wr_addr_s, rd_addr_s, err_addr_s;
    logic [UW-1:0]   wr_data_s, rd_data_s;
    logic [BWW-1:0]  bw_n_s;
    logic [15:0]     pass_cnt_s;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int            due;
        logic [AW-1:0] addr;
    } ret_t;

    logic [UW-1:0] mem [0:255];
    ret_t          pipe [$];
    ret_t          r_cur;
    int            exp_wr_q [$];
    int            exp_rd_q [$];
    int            lat, cyc, corrupt_a, corrupt_b;
    int            wr_seen, rd_seen, val_seen, inflight, peak, over_issue;
    int            first_wr_cyc, last_wr_cyc, exp_a;
    logic [DW-1:0] cap5;
    bit            extra_en, pend_extra;

    int            wr_s_seen, rd_s_seen, s_due;
    logic [UW-1:0] s_mem;

    qdr_traffic_gen dut (
        .clk(clk), .rst(rst), .init_calib_complete(icc), .start(start),
        .app_wr_cmd0(wr_cmd), .app_wr_addr0(wr_addr), .app_wr_data0(wr_data),
        .app_wr_bw_n0(bw_n), .app_rd_cmd0(rd_cmd), .app_rd_addr0(rd_addr),
        .app_rd_valid0(rd_valid), .app_rd_data0(rd_data), .busy(busy),
        .tg_compare_error(tg_err), .err_addr(err_addr), .pass_cnt(pass_cnt)
    );

    qdr_traffic_gen #(.START_ADDR(7), .END_ADDR(7)) dut_s (
        .clk(clk), .rst(rst), .init_calib_complete(icc_s), .start(start_s),
        .app_wr_cmd0(wr_cmd_s), .app_wr_addr0(wr_addr_s), .app_wr_data0(wr_data_s),
        .app_wr_bw_n0(bw_n_s), .app_rd_cmd0(rd_cmd_s), .app_rd_addr0(rd_addr_s),
        .app_rd_valid0(rd_valid_s), .app_rd_data0(rd_data_s), .busy(busy_s),
        .tg_compare_error(tg_err_s), .err_addr(err_addr_s), .pass_cnt(pass_cnt_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [UW-1:0] pat(input int addr);
        logic [UW-1:0] b;
        logic [DW-1:0] w;
        b = '0;
        for (int k = 0; k < BL; k++) begin
            w = (DW'(addr) << 2) | DW'(k);
            b[k*DW +: DW] = w ^ SEED;
        end
        return b;
    endfunction

    task automatic chk(input string tag, input logic [UW-1:0] obs, input logic [UW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_pass();
        for (int a = 0; a < 256; a++) begin
            exp_wr_q.push_back(a);
            exp_rd_q.push_back(a);
        end
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_timeout"}, UW'(n < budget), UW'(1));
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        icc   = 1'b0;
        start = 1'b0;
        step();
        exp_wr_q.delete();
        exp_rd_q.delete();
        wr_seen = 0; rd_seen = 0; val_seen = 0; peak = 0; over_issue = 0;
        first_wr_cyc = 0; last_wr_cyc = 0; cap5 = '0;
        corrupt_a = -1; corrupt_b = -1; extra_en = 1'b0; lat = 10;
        rst = 1'b0;
        step();
    endtask

    // Controller model for the full-range instance: memory, in-order fixed-latency returns.
    initial begin
        rd_valid = 1'b0;
        rd_data  = '0;
        cyc      = 0;
        inflight = 0;
        pend_extra = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            rd_valid = 1'b0;
            if (rst) begin
                pipe.delete();
                inflight   = 0;
                pend_extra = 1'b0;
                continue;
            end
            if (wr_cmd) begin
                if (wr_seen == 0) first_wr_cyc = cyc;
                last_wr_cyc = cyc;
                wr_seen++;
                mem[wr_addr[7:0]] = wr_data;
                if (wr_addr == 18'd5) cap5 = wr_data[DW-1:0];
                if (exp_wr_q.size() == 0) begin
                    chk("unexpected_write", UW'(wr_addr), UW'(0) - 1);
                end else begin
                    exp_a = exp_wr_q.pop_front();
                    chk("wr_addr", UW'(wr_addr), UW'(exp_a));
                    chk("wr_data", wr_data, pat(exp_a));
                    chk("wr_bw_n", UW'(bw_n), UW'(0));
                end
            end
            if (rd_cmd) begin
                if (inflight >= 16) over_issue++;
                rd_seen++;
                inflight++;
                if (inflight > peak) peak = inflight;
                if (exp_rd_q.size() == 0) begin
                    chk("unexpected_read", UW'(rd_addr), UW'(0) - 1);
                end else begin
                    exp_a = exp_rd_q.pop_front();
                    chk("rd_addr", UW'(rd_addr), UW'(exp_a));
                end
                pipe.push_back('{cyc + lat, rd_addr});
            end
            if (pipe.size() > 0 && pipe[0].due <= cyc) begin
                r_cur   = pipe.pop_front();
                rd_data = mem[r_cur.addr[7:0]];
                if (int'(r_cur.addr) == corrupt_a || int'(r_cur.addr) == corrupt_b)
                    rd_data[2*DW+3] = ~rd_data[2*DW+3];
                rd_valid = 1'b1;
                val_seen++;
                inflight--;
                if (pipe.size() == 0 && extra_en) pend_extra = 1'b1;
            end else if (pend_extra) begin
                rd_valid   = 1'b1;
                rd_data    = pat(0);
                pend_extra = 1'b0;
                extra_en   = 1'b0;
            end
        end
    end

    // Controller model for the single-address instance, three-cycle read latency.
    initial begin
        rd_valid_s = 1'b0;
        rd_data_s  = '0;
        s_due      = 0;
        wr_s_seen  = 0;
        rd_s_seen  = 0;
        forever begin
            @(negedge clk);
            rd_valid_s = 1'b0;
            if (rst) begin
                s_due = 0;
                continue;
            end
            if (wr_cmd_s) begin
                wr_s_seen++;
                s_mem = wr_data_s;
                chk("s_wr_addr", UW'(wr_addr_s), UW'(7));
                chk("s_wr_data", wr_data_s, pat(7));
            end
            if (rd_cmd_s) begin
                rd_s_seen++;
                chk("s_rd_addr", UW'(rd_addr_s), UW'(7));
                s_due = 3;
            end else if (s_due > 0) begin
                s_due--;
                if (s_due == 0) begin
                    rd_valid_s = 1'b1;
                    rd_data_s  = s_mem;
                end
            end
        end
    end

    initial begin
        int n;
        rst = 1'b1; icc = 1'b0; start = 1'b0; icc_s = 1'b0; start_s = 1'b0;
        lat = 10; corrupt_a = -1; corrupt_b = -1; extra_en = 1'b0;
        wr_seen = 0; rd_seen = 0; val_seen = 0; peak = 0; over_issue = 0;
        repeat (3) step();

        chk("rst_wr_cmd",   UW'(wr_cmd),   UW'(0));
        chk("rst_rd_cmd",   UW'(rd_cmd),   UW'(0));
        chk("rst_bw_n",     UW'(bw_n),     UW'(16'hFFFF));
        chk("rst_wr_addr",  UW'(wr_addr),  UW'(0));
        chk("rst_wr_data",  wr_data,       UW'(0));
        chk("rst_rd_addr",  UW'(rd_addr),  UW'(0));
        chk("rst_busy",     UW'(busy),     UW'(0));
        chk("rst_err",      UW'(tg_err),   UW'(0));
        chk("rst_err_addr", UW'(err_addr), UW'(0));
        chk("rst_pass_cnt", UW'(pass_cnt), UW'(0));
        rst = 1'b0;
        step();

        // Single-address range: one write and one read per pass, start held for several passes.
        icc_s = 1'b1; start_s = 1'b1;
        n = 0;
        while (pass_cnt_s != 16'd2 && n < 500) begin step(); n++; end
        chk("s_two_passes_timeout", UW'(n < 500), UW'(1));
        start_s = 1'b0;
        n = 0;
        while (busy_s !== 1'b0 && n < 100) begin step(); n++; end
        chk("s_idle_timeout", UW'(n < 100), UW'(1));
        chk("s_pass_cnt",  UW'(pass_cnt_s), UW'(3));
        chk("s_wr_count",  UW'(wr_s_seen),  UW'(3));
        chk("s_rd_count",  UW'(rd_s_seen),  UW'(3));
        chk("s_err",       UW'(tg_err_s),   UW'(0));
        icc_s = 1'b0;

        // Full pass, 10-cycle latency; start drops mid-pass and the pass still completes.
        do_reset();
        push_pass();
        icc = 1'b1; start = 1'b1;
        step(); step();
        start = 1'b0;
        wait_idle("t1_pass", 3000);
        chk("t1_wr_count",        UW'(wr_seen), UW'(256));
        chk("t1_wr_back_to_back", UW'(last_wr_cyc - first_wr_cyc), UW'(255));
        chk("t1_word0_a5",        UW'(cap5), UW'(36'h014 ^ SEED));
        chk("t1_rd_count",        UW'(rd_seen), UW'(256));
        chk("t1_val_count",       UW'(val_seen), UW'(256));
        chk("t1_rd_sb_empty",     UW'(exp_rd_q.size()), UW'(0));
        chk("t1_pass_cnt",        UW'(pass_cnt), UW'(1));
        chk("t1_err",             UW'(tg_err), UW'(0));

        // 40-cycle latency: outstanding limit must throttle reads at exactly 16.
        do_reset();
        lat = 40;
        push_pass();
        icc = 1'b1; start = 1'b1;
        step(); step();
        start = 1'b0;
        wait_idle("t2_pass", 5000);
        chk("t2_peak",       UW'(peak), UW'(16));
        chk("t2_over_issue", UW'(over_issue), UW'(0));
        chk("t2_rd_count",   UW'(rd_seen), UW'(256));
        chk("t2_pass_cnt",   UW'(pass_cnt), UW'(1));
        chk("t2_err",        UW'(tg_err), UW'(0));

        // Corrupted returns at 37 and 90: flag one cycle after the 38th valid, first address kept.
        do_reset();
        corrupt_a = 37; corrupt_b = 90;
        push_pass();
        icc = 1'b1; start = 1'b1;
        step(); step();
        start = 1'b0;
        n = 0;
        while (val_seen < 38 && n < 2000) begin step(); n++; end
        chk("t3_reach38_timeout", UW'(n < 2000), UW'(1));
        chk("t3_err_before", UW'(tg_err), UW'(0));
        step();
        chk("t3_err_rise",   UW'(tg_err), UW'(1));
        chk("t3_err_addr",   UW'(err_addr), UW'(37));
        wait_idle("t3_pass", 3000);
        chk("t3_err_addr_end", UW'(err_addr), UW'(37));
        chk("t3_err_sticky",   UW'(tg_err), UW'(1));
        chk("t3_pass_cnt",     UW'(pass_cnt), UW'(0));

        // Calibration lost after 100 reads: abort, no more strobes, late (corrupt) returns ignored.
        do_reset();
        corrupt_a = 99;
        push_pass();
        icc = 1'b1; start = 1'b1;
        n = 0;
        while (rd_seen < 100 && n < 2000) begin step(); n++; end
        chk("t4_reach100_timeout", UW'(n < 2000), UW'(1));
        icc = 1'b0;
        step();
        chk("t4_busy",   UW'(busy), UW'(0));
        chk("t4_rd_cmd", UW'(rd_cmd), UW'(0));
        chk("t4_wr_cmd", UW'(wr_cmd), UW'(0));
        repeat (40) step();
        chk("t4_rd_count",  UW'(rd_seen), UW'(100));
        chk("t4_val_count", UW'(val_seen), UW'(100));
        chk("t4_err",       UW'(tg_err), UW'(0));
        chk("t4_pass_cnt",  UW'(pass_cnt), UW'(0));
        chk("t4_bw_n",      UW'(bw_n), UW'(16'hFFFF));
        chk("t4_still_idle", UW'(busy), UW'(0));

        // Spurious return in DRAIN with nothing outstanding, then asynchronous reset mid-pass.
        do_reset();
        extra_en = 1'b1;
        push_pass();
        push_pass();
        icc = 1'b1; start = 1'b1;
        n = 0;
        while (val_seen < 256 && n < 3000) begin step(); n++; end
        chk("t5_reach256_timeout", UW'(n < 3000), UW'(1));
        step();
        chk("t5_err_before", UW'(tg_err), UW'(0));
        step();
        chk("t5_err_spurious",  UW'(tg_err), UW'(1));
        chk("t5_outstanding_0", UW'(dut.outstanding_q), UW'(0));
        n = 0;
        while (wr_seen < 266 && n < 500) begin step(); n++; end
        chk("t5_second_pass_timeout", UW'(n < 500), UW'(1));
        chk("t5_mid_pass_wr", UW'(wr_cmd), UW'(1));
        rst = 1'b1;
        #1;
        chk("t5_rst_wr_cmd",   UW'(wr_cmd),   UW'(0));
        chk("t5_rst_rd_cmd",   UW'(rd_cmd),   UW'(0));
        chk("t5_rst_bw_n",     UW'(bw_n),     UW'(16'hFFFF));
        chk("t5_rst_wr_addr",  UW'(wr_addr),  UW'(0));
        chk("t5_rst_wr_data",  wr_data,       UW'(0));
        chk("t5_rst_rd_addr",  UW'(rd_addr),  UW'(0));
        chk("t5_rst_busy",     UW'(busy),     UW'(0));
        chk("t5_rst_err",      UW'(tg_err),   UW'(0));
        chk("t5_rst_err_addr", UW'(err_addr), UW'(0));
        chk("t5_rst_pass_cnt", UW'(pass_cnt), UW'(0));
        step();
        rst = 1'b0;
        start = 1'b0;
        icc = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
